seq_alu: RTL and testbench

//   Parametrised multi-cycle ALU for the multi-cycle MIPS datapath.

---
 rtl/seq_alu.sv | 151 +++++++++++++++
 tb/tb_seq_alu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the multi-cycle MIPS datapath.
// Single-cycle ops (and/or/add/sub/slt/sltu) complete one cycle after start;
// mult (shift-add) and divu (restoring) iterate WIDTH steps behind a
// start/busy/done handshake. Results and flags are held until the next
// completion.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUcontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t           r_state;
  logic             r_busy, r_done, r_zero, r_ovf, r_dbz, r_is_div;
  logic [WIDTH-1:0] r_out, r_hi;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opnd;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_sum, w_diff, w_res;
  logic             w_ovf, w_multi;
  logic [WIDTH:0]   w_madd, w_rem_sh;
  logic [WIDTH-1:0] w_rem_sub, w_hi_n, w_lo_n;
  logic             w_ge;

  assign w_sum   = srca + srcb;
  assign w_diff  = srca - srcb;
  assign w_multi = (ALUcontrol == 3'd3) || (ALUcontrol == 3'd4);

  // Single-cycle result and signed-overflow flag from the live operands.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALUcontrol)
      3'd0: w_res = srca & srcb;
      3'd1: w_res = srca | srcb;
      3'd2: begin
        w_res = w_sum;
        w_ovf = (srca[WIDTH-1] == srcb[WIDTH-1]) && (w_sum[WIDTH-1] != srca[WIDTH-1]);
      end
      3'd5: w_res = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      3'd6: begin
        w_res = w_diff;
        w_ovf = (srca[WIDTH-1] != srcb[WIDTH-1]) && (w_diff[WIDTH-1] != srca[WIDTH-1]);
      end
      3'd7: w_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: w_res = '0;
    endcase
  end

  // One iteration step: shift-add for mult, restoring subtract for divu.
  // For divu, r_acc_hi is the partial remainder and r_acc_lo shifts the
  // dividend out at the top while quotient bits enter at the bottom. A zero
  // divisor naturally yields an all-ones quotient and remainder == dividend.
  always_comb begin
    w_madd    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    w_rem_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;
    if (r_is_div) begin
      if (w_ge) begin
        w_hi_n = w_rem_sub;
        w_lo_n = {r_acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_n = w_rem_sh[WIDTH-1:0];
        w_lo_n = {r_acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_n = w_madd[WIDTH:1];
      w_lo_n = {w_madd[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // Control FSM with registered outputs; working operands are not reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_hi    <= '0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_multi) begin
              r_is_div <= (ALUcontrol == 3'd4);
              r_acc_hi <= '0;
              r_acc_lo <= srca;
              r_opnd   <= srcb;
              r_count  <= CW'(WIDTH);
              r_busy   <= 1'b1;
              r_state  <= S_ITER;
            end else begin
              r_out  <= w_res;
              r_hi   <= '0;
              r_zero <= (w_res == '0);
              r_ovf  <= w_ovf;
              r_dbz  <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        S_ITER: begin
          r_acc_hi <= w_hi_n;
          r_acc_lo <= w_lo_n;
          r_count  <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            r_out   <= w_lo_n;
            r_hi    <= w_hi_n;
            r_zero  <= (w_lo_n == '0);
            r_ovf   <= 1'b0;
            r_dbz   <= r_is_div && (r_opnd == '0);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;
  assign hi   = r_hi;
  assign zero = r_zero;
  assign ovf  = r_ovf;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [2:0]    ALUcontrol;
  logic [W-1:0]  srca, srcb;
  logic          busy, done;
  logic [W-1:0]  out, hi;
  logic          zero, ovf, dbz;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_out, exp_hi;
  logic         exp_zero, exp_ovf, exp_dbz, exp_multi;
  int           exp_lat;
  int           inject_at = -1;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUcontrol(ALUcontrol),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done), .out(out),
    .hi(hi), .zero(zero), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: results straight from the arithmetic definitions.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    logic [63:0] p;
    exp_hi = '0; exp_ovf = 1'b0; exp_dbz = 1'b0; exp_multi = 1'b0; exp_lat = 1;
    case (op)
      3'd0: exp_out = a & b;
      3'd1: exp_out = a | b;
      3'd2: begin
        s = longint'($signed(a)) + longint'($signed(b));
        exp_out = a + b;
        exp_ovf = (s > SMAX) || (s < SMIN);
      end
      3'd3: begin
        p = 64'(a) * 64'(b);
        exp_out = p[31:0]; exp_hi = p[63:32];
        exp_multi = 1'b1; exp_lat = W + 1;
      end
      3'd4: begin
        if (b == 0) begin
          exp_out = '1; exp_hi = a; exp_dbz = 1'b1;
        end else begin
          exp_out = a / b; exp_hi = a % b;
        end
        exp_multi = 1'b1; exp_lat = W + 1;
      end
      3'd5: exp_out = (a < b) ? 32'd1 : 32'd0;
      3'd6: begin
        s = longint'($signed(a)) - longint'($signed(b));
        exp_out = a - b;
        exp_ovf = (s > SMAX) || (s < SMIN);
      end
      default: exp_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    exp_zero = (exp_out == 0);
  endtask

  // Called at a falling edge: present one request for one rising edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    model(op, a, b);
    start = 1'b1; ALUcontrol = op; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
    ALUcontrol = 3'($urandom); srca = $urandom; srcb = $urandom;
  endtask

  // Wait (bounded) for done, scrambling inputs meanwhile; then check results.
  task automatic wait_done(input string tag);
    int cycles = 1;
    int busy_bad = 0;
    while (!done && cycles < W + 8) begin
      if (busy !== exp_multi) busy_bad++;
      if (cycles == inject_at) begin
        start = 1'b1; ALUcontrol = 3'd7;
      end else begin
        start = 1'b0; ALUcontrol = 3'($urandom);
      end
      srca = $urandom; srcb = $urandom;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_out"}, 64'(out), 64'(exp_out));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_flags"}, {61'd0, zero, ovf, dbz}, {61'd0, exp_zero, exp_ovf, exp_dbz});
  endtask

  initial begin
    int ndone;
    logic [2:0] op;
    logic [W-1:0] a, b;
    reset = 1'b1; start = 1'b0; ALUcontrol = 3'd0; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ctrl", {62'd0, busy, done}, 64'd0);
    check("rst_out", {out, hi}, 64'd0);
    check("rst_flags", {61'd0, zero, ovf, dbz}, 64'd4);

    issue(3'd2, 32'd5, 32'd7);                 wait_done("add");
    @(negedge clk);
    check("hold_done", 64'(done), 64'd0);
    check("hold_out", 64'(out), 64'd12);
    issue(3'd6, 32'h7FFFFFFF, 32'hFFFFFFFF);   wait_done("sub_ovf");
    issue(3'd6, 32'd3, 32'd3);                 wait_done("sub_zero");
    issue(3'd3, 32'hFFFFFFFF, 32'd2);          wait_done("mult");
    issue(3'd4, 32'd100, 32'd7);               wait_done("divu");
    issue(3'd4, 32'd9, 32'd0);                 wait_done("divu_dbz");

    // start during busy is ignored, then back-to-back in the done cycle
    inject_at = 4;
    issue(3'd3, 32'hFFFFFFFF, 32'd2);          wait_done("mult_ign");
    inject_at = -1;
    issue(3'd5, 32'hFFFFFFFF, 32'd1);          wait_done("sltu_b2b");
    issue(3'd7, 32'hFFFFFFFF, 32'd1);          wait_done("slt_b2b");

    // reset in the middle of a divu aborts it
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ctrl", {62'd0, busy, done}, 64'd0);
    check("abort_out", {out, hi}, 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    ndone = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    issue(3'd0, 32'h0000F0F0, 32'h00000FF0);   wait_done("and");

    // reset and start together: request dropped
    reset = 1'b1; start = 1'b1; ALUcontrol = 3'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start", {62'd0, busy, done}, 64'd0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: a = 32'h7FFFFFFF;
        2: b = a;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue(op, a, b);
      wait_done("rnd");
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("rnd_hold", {31'd0, done, out}, {31'd0, 1'b0, exp_out});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
